fft2d_stream_tx: RTL and testbench
==================================

Name: fft2d_stream_tx

Overview:
- Output-side transmitter for the 2D FFT result matrix.
- Captures the full n_point x n_point result array when the 2D FFT controller raises its completion flag.
- Serialises the captured array as a 64-bit AXI4-Stream master: row-major or column-major order, per-line tlast, frame-start tuser.
- Sits between the 2D FFT controller outputs (out_2d, data_tlast) and a downstream DMA/consumer that applies backpressure.

Parameters:
- n_point, 8, matrix dimension; power of two, 2..64.
- col_major, 0, 0 = emit out_2d[r][c] with c fastest; 1 = emit with r fastest, i.e. the transposed stream.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inp_2d  input  64 x [0:n_point-1][0:n_point-1]  result matrix; each element is {imag[31:0], real[31:0]}, passed through untouched.
- frame_done  input  1  completion flag from the 2D FFT; level, may stay high indefinitely; a capture is triggered by its rising edge.
- m_axis_tdata  output  64  current sample.
- m_axis_tvalid  output  1  sample valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  high on the last sample of each line (row, or column when col_major=1).
- m_axis_tuser  output  1  high on the first sample of each frame.
- busy  output  1  high while a captured frame is not fully transmitted.
- frame_drop  output  1  one-cycle pulse when a trigger is ignored.

Behaviour:
- Reset values: tdata=0, tvalid=0, tlast=0, tuser=0, busy=0, frame_drop=0, done_q=0, counters=0, state=IDLE. Reset mid-frame abandons the frame immediately; nothing resumes.
- Trigger detection:
  - done_q is frame_done registered; trigger = frame_done & ~done_q.
  - If frame_done is already high when reset is released, no trigger fires until it falls and rises again.
- FSM: IDLE, STREAM.
  - IDLE + trigger (sampled at edge N):
    - latch all inp_2d into the frame buffer;
    - load the output register with element (0,0), tuser=1, tlast = (n_point==1 ? 1 : 0);
    - tvalid=1 and busy=1 from cycle N+1; go to STREAM.
  - STREAM, beat handshake (tvalid & tready):
    - advance the inner index; on inner wrap, advance the outer index;
    - load the next element into the output register in the same edge (zero-bubble: one beat per cycle while tready=1).
  - STREAM, no handshake: tdata, tlast and tuser hold stable; tvalid is never withdrawn.
  - STREAM, handshake of element (n_point-1, n_point-1): next state IDLE, tvalid=0, busy=0.
  - Exception in that same cycle: if a trigger also occurs, the new frame is captured and the FSM stays in STREAM, with element (0,0) of the new frame presented next cycle, tuser=1.
- Trigger in STREAM (any other cycle): frame not captured, frame_drop=1 for one cycle, the frame in flight is unaffected.
- Frame buffer is written only at capture; changes on inp_2d during streaming are invisible.
- Ordering and sideband:
  - col_major=0: index (r,c), c inner.
  - col_major=1: index (r,c), r inner.
  - tlast on inner index == n_point-1.
  - tuser only on (0,0).
- Counters are $clog2(n_point) bits; a frame is exactly n_point*n_point beats.
- Throughput: n_point*n_point cycles per frame with tready held high. Minimum trigger-to-first-beat latency is 1 cycle.

Decomposition:
- Shared package fft_pkg:
  - typedef cplx_t as a 64-bit packed struct {imag, real}.
  - constant N_POINT_DEFAULT = 8.
  - localparam-derived IDX_W function.
- One sub-module, fft2d_axis_out_reg: a single-entry AXI output register holding data, last, user and valid, with load/hold control.
- Index counters and the FSM stay in the top module.

Test Plan:
- Basic order: matrix element (r,c) = {32'(r), 32'(c)}, col_major=0, tready=1; raise frame_done.
  - Expect 64 beats over 64 consecutive cycles, starting the cycle after the edge.
  - Beat k has tdata={k/8, k%8}, tlast on k=7,15,...,63, tuser only on k=0; busy falls after beat 63.
- Transpose: same stimulus with col_major=1.
  - Beat k has tdata={k%8, k/8}; tlast every 8th beat.
- Backpressure: tready toggled in a pseudo-random pattern (seed 1), ~50% duty.
  - All 64 beats arrive in order, none lost or duplicated.
  - tdata, tlast and tuser are stable whenever tvalid=1 and tready=0.
- Level trigger and drop:
  - Holding frame_done high for 200 cycles yields exactly one frame.
  - A second rising edge at beat 20 gives a frame_drop pulse with the stream intact.
  - An edge coincident with the handshake of beat 63 starts a new frame next cycle with tuser=1 and no drop.
- Buffer isolation: change inp_2d to all 0xFFFF_FFFF_FFFF_FFFF at beat 10.
  - Remaining beats still carry the captured values.
- Reset mid-frame: assert rst at beat 30.
  - Outputs are 0 asynchronously.
  - After release with frame_done still high, no transmission until a fresh rising edge.

Source files
------------

// File: rtl/fft2d_stream_tx_pkg.sv
// Shared types and helpers for the 2D FFT output streaming path.
package fft_pkg;

    localparam int CPLX_W          = 64;
    localparam int N_POINT_DEFAULT = 8;

    // One matrix element: imaginary part in the upper word, real part in the lower word.
    typedef struct packed {
        logic [31:0] im;
        logic [31:0] re;
    } cplx_t;

    typedef enum logic {
        IDLE,
        STREAM
    } tx_state_t;

    // Index counter width for an n x n matrix; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft2d_stream_tx_axis_out_reg.sv
// Single-entry AXI4-Stream output register: load a new beat, clear valid, or hold.
module fft2d_axis_out_reg
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CPLX_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              ld_user,
    output logic [CPLX_W-1:0] data,
    output logic              last,
    output logic              user,
    output logic              valid
);

    // Beat register; load wins over clear, otherwise everything holds for backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            last  <= 1'b0;
            user  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= ld_data;
            last  <= ld_last;
            user  <= ld_user;
            valid <= 1'b1;
        end else if (clear) begin
            last  <= 1'b0;
            user  <= 1'b0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft2d_stream_tx.sv
// Captures the 2D FFT result matrix on a frame_done rising edge and streams it
// out over AXI4-Stream in row-major or column-major order.
module fft2d_stream_tx
    import fft_pkg::*;
#(
    parameter int n_point   = N_POINT_DEFAULT,
    parameter bit col_major = 1'b0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CPLX_W-1:0] inp_2d [0:n_point-1][0:n_point-1],
    input  logic              frame_done,
    output logic [CPLX_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              busy,
    output logic              frame_drop
);

    localparam int               IDX_W   = idx_w(n_point);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(n_point - 1);

    tx_state_t         state;
    logic [IDX_W-1:0]  inner;
    logic [IDX_W-1:0]  outer;
    logic              done_q;
    logic              armed;
    logic              busy_q;
    logic              drop_q;

    logic [CPLX_W-1:0] fbuf [0:n_point-1][0:n_point-1];

    logic              trigger;
    logic              hs;
    logic              last_elem;
    logic              capture;
    logic [IDX_W-1:0]  inner_nx;
    logic [IDX_W-1:0]  outer_nx;
    logic [IDX_W-1:0]  row_nx;
    logic [IDX_W-1:0]  col_nx;
    cplx_t             elem_nx;

    logic              ld;
    logic              clr;
    logic [CPLX_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_user;

    // armed stays low after reset until frame_done has been seen low, so a level
    // that is already high at reset release does not count as an edge.
    assign trigger   = frame_done & ~done_q & armed;
    assign hs        = m_axis_tvalid & m_axis_tready;
    assign last_elem = (state == STREAM) && (inner == IDX_MAX) && (outer == IDX_MAX);
    assign capture   = trigger & ((state == IDLE) | (hs & last_elem));

    assign inner_nx = inner + 1'b1;
    assign outer_nx = (inner == IDX_MAX) ? outer + 1'b1 : outer;
    assign row_nx   = col_major ? inner_nx : outer_nx;
    assign col_nx   = col_major ? outer_nx : inner_nx;
    assign elem_nx  = cplx_t'(fbuf[row_nx][col_nx]);

    // Frame buffer: written only on capture, so input changes mid-frame are invisible.
    always_ff @(posedge clk) begin
        if (capture) begin
            fbuf <= inp_2d;
        end
    end

    // Decide what the output register does this cycle; element (0,0) comes straight
    // from the input because the buffer is written on the same edge.
    always_comb begin
        ld      = 1'b0;
        clr     = 1'b0;
        ld_data = '0;
        ld_last = 1'b0;
        ld_user = 1'b0;
        if (capture) begin
            ld      = 1'b1;
            ld_data = inp_2d[0][0];
            ld_last = (n_point == 1);
            ld_user = 1'b1;
        end else if ((state == STREAM) && hs) begin
            if (last_elem) begin
                clr = 1'b1;
            end else begin
                ld      = 1'b1;
                ld_data = elem_nx;
                ld_last = (inner_nx == IDX_MAX);
                ld_user = 1'b0;
            end
        end
    end

    // Control FSM with trigger edge detect, index counters, busy and drop flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            inner  <= '0;
            outer  <= '0;
            done_q <= 1'b0;
            armed  <= 1'b0;
            busy_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            done_q <= frame_done;
            armed  <= armed | ~frame_done;
            drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state  <= STREAM;
                        busy_q <= 1'b1;
                        inner  <= '0;
                        outer  <= '0;
                    end
                end
                STREAM: begin
                    if (hs && last_elem) begin
                        inner <= '0;
                        outer <= '0;
                        if (!trigger) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        if (hs) begin
                            inner <= inner_nx;
                            outer <= outer_nx;
                        end
                        if (trigger) begin
                            drop_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fft2d_axis_out_reg u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (ld),
        .clear   (clr),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .ld_user (ld_user),
        .data    (m_axis_tdata),
        .last    (m_axis_tlast),
        .user    (m_axis_tuser),
        .valid   (m_axis_tvalid)
    );

    assign busy       = busy_q;
    assign frame_drop = drop_q;

endmodule

// File: tb/tb_fft2d_stream_tx.sv
// Bench for fft2d_stream_tx: a row-major and a column-major instance share the
// stimulus; each has its own expected-beat queue checked on every handshake.
module tb_fft2d_stream_tx;

    localparam int N = 8;

    logic        clk;
    logic        rst;
    logic        frame_done;
    logic        tready;
    logic [63:0] mat [0:N-1][0:N-1];

    logic [63:0] r_tdata, c_tdata;
    logic        r_tvalid, c_tvalid;
    logic        r_tlast, c_tlast;
    logic        r_tuser, c_tuser;
    logic        r_busy, c_busy;
    logic        r_drop, c_drop;

    logic [65:0] q_r[$];
    logic [65:0] q_c[$];
    logic [65:0] exp_r, exp_c;

    int checks;
    int errors;
    int beats_r;
    int beats_c;

    fft2d_stream_tx #(.n_point(N), .col_major(1'b0)) dut_r (
        .clk           (clk),
        .rst           (rst),
        .inp_2d        (mat),
        .frame_done    (frame_done),
        .m_axis_tdata  (r_tdata),
        .m_axis_tvalid (r_tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (r_tlast),
        .m_axis_tuser  (r_tuser),
        .busy          (r_busy),
        .frame_drop    (r_drop)
    );

    fft2d_stream_tx #(.n_point(N), .col_major(1'b1)) dut_c (
        .clk           (clk),
        .rst           (rst),
        .inp_2d        (mat),
        .frame_done    (frame_done),
        .m_axis_tdata  (c_tdata),
        .m_axis_tvalid (c_tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (c_tlast),
        .m_axis_tuser  (c_tuser),
        .busy          (c_busy),
        .frame_drop    (c_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake pops and compares one expected beat per instance.
    always @(negedge clk) begin
        if (!rst && r_tvalid && tready) begin
            beats_r++;
            checks++;
            if (q_r.size() == 0) begin
                errors++;
                $display("FAIL row_beat unexpected beat data=%h last=%b user=%b", r_tdata, r_tlast, r_tuser);
            end else begin
                exp_r = q_r.pop_front();
                if ({r_tdata, r_tlast, r_tuser} !== exp_r) begin
                    errors++;
                    $display("FAIL row_beat got %h/%b/%b expected %h/%b/%b",
                             r_tdata, r_tlast, r_tuser, exp_r[65:2], exp_r[1], exp_r[0]);
                end
            end
        end
        if (!rst && c_tvalid && tready) begin
            beats_c++;
            checks++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL col_beat unexpected beat data=%h last=%b user=%b", c_tdata, c_tlast, c_tuser);
            end else begin
                exp_c = q_c.pop_front();
                if ({c_tdata, c_tlast, c_tuser} !== exp_c) begin
                    errors++;
                    $display("FAIL col_beat got %h/%b/%b expected %h/%b/%b",
                             c_tdata, c_tlast, c_tuser, exp_c[65:2], exp_c[1], exp_c[0]);
                end
            end
        end
    end

    task automatic set_index_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = {32'(r), 32'(c)};
    endtask

    // Expected stream of the matrix as it stands now, for both orders.
    task automatic push_frame();
        for (int o = 0; o < N; o++)
            for (int i = 0; i < N; i++) begin
                q_r.push_back({mat[o][i], (i == N - 1), (o == 0 && i == 0)});
                q_c.push_back({mat[i][o], (i == N - 1), (o == 0 && i == 0)});
            end
    endtask

    task automatic settle();
        @(posedge clk);
        #1 frame_done = 1'b0;
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        beats_r = 0;
        beats_c = 0;
    endtask

    task automatic check_queues_empty(input string name);
        checks++;
        if (q_r.size() != 0 || q_c.size() != 0) begin
            errors++;
            $display("FAIL %s leftover row=%0d col=%0d required 0", name, q_r.size(), q_c.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_done = 1'b0;
        tready = 1'b1;
        set_index_mat();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({r_tdata, r_tvalid, r_tlast, r_tuser, r_busy, r_drop} !== 69'd0) begin
            errors++;
            $display("FAIL reset_row got data=%h v=%b l=%b u=%b busy=%b drop=%b required all 0",
                     r_tdata, r_tvalid, r_tlast, r_tuser, r_busy, r_drop);
        end
        checks++;
        if ({c_tdata, c_tvalid, c_tlast, c_tuser, c_busy, c_drop} !== 69'd0) begin
            errors++;
            $display("FAIL reset_col got data=%h v=%b l=%b u=%b busy=%b drop=%b required all 0",
                     c_tdata, c_tvalid, c_tlast, c_tuser, c_busy, c_drop);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        settle();
    endtask

    task automatic test_basic_order();
        set_index_mat();
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        @(posedge clk);
        for (int i = 1; i <= N * N + 1; i++) begin
            @(negedge clk);
            checks++;
            if (r_tvalid !== (i <= N * N) || r_busy !== (i <= N * N)) begin
                errors++;
                $display("FAIL basic_valid cycle %0d got valid=%b busy=%b required %b", i, r_tvalid, r_busy, (i <= N * N));
            end
            if (i == 1) begin
                checks++;
                if (r_tuser !== 1'b1 || c_tuser !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_first_user got row=%b col=%b required 1", r_tuser, c_tuser);
                end
            end
        end
        checks++;
        if (beats_r != N * N || beats_c != N * N) begin
            errors++;
            $display("FAIL basic_count got row=%0d col=%0d required %0d", beats_r, beats_c, N * N);
        end
        check_queues_empty("basic_queue");
        settle();
    endtask

    task automatic test_transpose();
        int lasts;
        lasts = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = {$urandom, $urandom};
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        @(posedge clk);
        for (int i = 1; i <= N * N + 1; i++) begin
            @(negedge clk);
            if (c_tvalid && c_tlast) lasts++;
        end
        checks++;
        if (lasts != N) begin
            errors++;
            $display("FAIL transpose_tlast got %0d required %0d", lasts, N);
        end
        check_queues_empty("transpose_queue");
        settle();
    endtask

    task automatic test_backpressure();
        logic [65:0] prev;
        logic        prev_hold;
        bit          done;
        void'($urandom(1));
        set_index_mat();
        prev_hold = 1'b0;
        prev = '0;
        done = 1'b0;
        @(posedge clk);
        #1 frame_done = 1'b1;
        tready = 1'($urandom_range(0, 1));
        push_frame();
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(posedge clk);
            #1 tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_hold) begin
                checks++;
                if (r_tvalid !== 1'b1 || {r_tdata, r_tlast, r_tuser} !== prev) begin
                    errors++;
                    $display("FAIL bp_stable got v=%b %h/%b/%b required v=1 %h/%b/%b",
                             r_tvalid, r_tdata, r_tlast, r_tuser, prev[65:2], prev[1], prev[0]);
                end
            end
            prev_hold = r_tvalid & ~tready;
            prev = {r_tdata, r_tlast, r_tuser};
            if (!r_busy && !c_busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL bp_timeout busy still high after 1000 cycles");
        end
        checks++;
        if (beats_r != N * N || beats_c != N * N) begin
            errors++;
            $display("FAIL bp_count got row=%0d col=%0d required %0d", beats_r, beats_c, N * N);
        end
        check_queues_empty("bp_queue");
        settle();
    endtask

    task automatic test_level_drop();
        // Level held high for 200 cycles: exactly one frame.
        set_index_mat();
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (r_tvalid !== (i <= N * N) || r_drop !== 1'b0) begin
                errors++;
                $display("FAIL level_hold cycle %0d got valid=%b drop=%b required %b/0", i, r_tvalid, r_drop, (i <= N * N));
            end
        end
        checks++;
        if (beats_r != N * N) begin
            errors++;
            $display("FAIL level_count got %0d required %0d", beats_r, N * N);
        end
        settle();
        // Second rising edge mid-frame: one drop pulse, stream untouched.
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        for (int i = 1; i <= N * N + 2; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) frame_done = 1'b0;
            if (i == 19) frame_done = 1'b1;
            @(negedge clk);
            checks++;
            if (r_drop !== (i == 20) || c_drop !== (i == 20) || r_tvalid !== (i <= N * N)) begin
                errors++;
                $display("FAIL drop_pulse cycle %0d got drop=%b/%b valid=%b required %b/%b",
                         i, r_drop, c_drop, r_tvalid, (i == 20), (i <= N * N));
            end
        end
        check_queues_empty("drop_queue");
        settle();
    endtask

    task automatic test_back_to_back();
        set_index_mat();
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        for (int i = 1; i <= 2 * N * N + 1; i++) begin
            @(posedge clk);
            #1;
            if (i == 30) frame_done = 1'b0;
            if (i == N * N) begin
                frame_done = 1'b1;
                push_frame();
            end
            @(negedge clk);
            checks++;
            if (r_tvalid !== (i <= 2 * N * N) || r_busy !== (i <= 2 * N * N) || r_drop !== 1'b0 || c_drop !== 1'b0) begin
                errors++;
                $display("FAIL b2b cycle %0d got valid=%b busy=%b drop=%b/%b", i, r_tvalid, r_busy, r_drop, c_drop);
            end
            if (i == N * N + 1) begin
                checks++;
                if (r_tuser !== 1'b1 || c_tuser !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_user got row=%b col=%b required 1", r_tuser, c_tuser);
                end
            end
        end
        checks++;
        if (beats_r != 2 * N * N) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", beats_r, 2 * N * N);
        end
        check_queues_empty("b2b_queue");
        settle();
    endtask

    task automatic test_buffer_isolation();
        set_index_mat();
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        for (int i = 1; i <= N * N + 1; i++) begin
            @(posedge clk);
            #1;
            if (i == 11) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        mat[r][c] = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            @(negedge clk);
        end
        checks++;
        if (beats_r != N * N || beats_c != N * N) begin
            errors++;
            $display("FAIL iso_count got row=%0d col=%0d required %0d", beats_r, beats_c, N * N);
        end
        check_queues_empty("iso_queue");
        set_index_mat();
        settle();
    endtask

    task automatic test_reset_mid();
        set_index_mat();
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({r_tdata, r_tvalid, r_tlast, r_tuser, r_busy} !== 68'd0 ||
            {c_tdata, c_tvalid, c_tlast, c_tuser, c_busy} !== 68'd0) begin
            errors++;
            $display("FAIL rst_async got row v=%b data=%h busy=%b col v=%b data=%h busy=%b required 0",
                     r_tvalid, r_tdata, r_busy, c_tvalid, c_tdata, c_busy);
        end
        q_r.delete();
        q_c.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        beats_r = 0;
        beats_c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (r_tvalid !== 1'b0 || r_busy !== 1'b0 || c_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL rst_level cycle %0d got valid=%b/%b busy=%b required 0", i, r_tvalid, c_tvalid, r_busy);
            end
        end
        @(posedge clk);
        #1 frame_done = 1'b0;
        @(posedge clk);
        #1 frame_done = 1'b1;
        push_frame();
        @(posedge clk);
        for (int i = 1; i <= N * N + 1; i++) begin
            @(negedge clk);
            checks++;
            if (r_tvalid !== (i <= N * N)) begin
                errors++;
                $display("FAIL rst_refire cycle %0d got valid=%b required %b", i, r_tvalid, (i <= N * N));
            end
        end
        check_queues_empty("rst_queue");
        settle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        beats_r = 0;
        beats_c = 0;
        test_reset();
        test_basic_order();
        test_transpose();
        test_backpressure();
        test_level_drop();
        test_back_to_back();
        test_buffer_isolation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

endmodule
